// File: rtl/shift_in_deser_if.sv
// Serial-in / parallel-out bundle for shift_in_deser.
// Serial side and word handshake share one interface instance.
interface shift_in_deser_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in;
    logic             start;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    bit_count;
    logic             overrun;

    modport master (
        output in_valid,
        output in,
        output start,
        output out_ready,
        input  out,
        input  out_valid,
        input  bit_count,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  in,
        input  start,
        input  out_ready,
        output out,
        output out_valid,
        output bit_count,
        output overrun
    );
endinterface

// File: rtl/shift_in_deser.sv
// Parametrised serial-to-parallel deserialiser with resync,
// valid/ready word output and sticky overrun.
module shift_in_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst,
    shift_in_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ovr_q;
    logic             ovr_d;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_base;
    logic             complete;
    logic             load;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sreg_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    // Resync folds into the same cycle's sample as bit 0
    always_comb begin
        base     = bus.start ? '0 : sreg_q;
        cnt_base = bus.start ? '0 : cnt_q;
        if (LSB_FIRST)
            shifted = {bus.in, base[WIDTH-1:1]};
        else
            shifted = {base[WIDTH-2:0], bus.in};
        complete = bus.in_valid && (cnt_base == LAST);
        sreg_d   = bus.in_valid ? shifted : base;
        cnt_d    = cnt_base;
        if (bus.in_valid)
            cnt_d = complete ? '0 : cnt_base + CW'(1);
        load  = complete && (state_q == EMPTY || bus.out_ready);
        out_d = load ? shifted : out_q;
        ovr_d = ovr_q
              | (complete && state_q == FULL && !bus.out_ready);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (complete) state_d = FULL;
            FULL:  if (!complete && bus.out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        bus.out       = out_q;
        bus.out_valid = (state_q == FULL);
        bus.bit_count = cnt_q;
        bus.overrun   = ovr_q;
    end
endmodule

// File: tb/tb_shift_in_deser.sv
// Bench for shift_in_deser: both bit orders fed the same stream,
// checked every cycle against a queue-based word model.
module tb_shift_in_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int ncmp = 0;
    int nerr = 0;

    shift_in_deser_if #(.WIDTH(W)) a ();
    shift_in_deser_if #(.WIDTH(W)) b ();

    shift_in_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bus(a.slave)
    );
    shift_in_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .bus(b.slave)
    );

    always #5 clk = ~clk;

    bit q[$];
    int m_out_l = 0;
    int m_out_m = 0;
    bit m_valid = 0;
    bit m_ovr   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit iv, input bit d, input bit st,
                         input bit rdy, input bit rs);
        bit comp;
        int wl;
        int wm;
        comp = 0;
        wl = 0;
        wm = 0;
        if (rs) begin
            q.delete();
            m_out_l = 0;
            m_out_m = 0;
            m_valid = 0;
            m_ovr = 0;
            return;
        end
        if (st) q.delete();
        if (iv) q.push_back(d);
        if (q.size() == W) begin
            for (int i = 0; i < W; i++) begin
                wl += int'(q[i]) * (1 << i);
                wm += int'(q[i]) * (1 << (W - 1 - i));
            end
            q.delete();
            comp = 1;
        end
        if (m_valid) begin
            if (comp && rdy) begin
                m_out_l = wl;
                m_out_m = wm;
            end else if (comp) begin
                m_ovr = 1;
            end else if (rdy) begin
                m_valid = 0;
            end
        end else if (comp) begin
            m_valid = 1;
            m_out_l = wl;
            m_out_m = wm;
        end
    endtask

    task automatic cyc(input bit iv, input bit d, input bit st,
                       input bit rdy, input bit rs);
        a.in_valid = iv;  b.in_valid = iv;
        a.in = d;         b.in = d;
        a.start = st;     b.start = st;
        a.out_ready = rdy; b.out_ready = rdy;
        rst = rs;
        @(posedge clk);
        model(iv, d, st, rdy, rs);
        #1;
        chk("out_lsb", 32'(a.out), m_out_l);
        chk("out_msb", 32'(b.out), m_out_m);
        chk("valid_lsb", 32'(a.out_valid), 32'(m_valid));
        chk("valid_msb", 32'(b.out_valid), 32'(m_valid));
        chk("cnt_lsb", 32'(a.bit_count), q.size());
        chk("cnt_msb", 32'(b.bit_count), q.size());
        chk("ovr_lsb", 32'(a.overrun), 32'(m_ovr));
        chk("ovr_msb", 32'(b.overrun), 32'(m_ovr));
    endtask

    task automatic send_word(input logic [7:0] w,
                             input logic [7:0] rdy);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, w[i], 1'b0, rdy[i], 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        a.in_valid = 0; b.in_valid = 0;
        a.in = 0;       b.in = 0;
        a.start = 0;    b.start = 0;
        a.out_ready = 0; b.out_ready = 0;

        // reset and idle
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++)
            cyc(0, 1'($urandom), 0, 1'($urandom), 0);

        // bit order: 0x8D lsb-first / 0xB1 msb-first
        pat = 8'b1000_1101;
        send_word(pat, 8'hFF);
        chk("order_lsb", 32'(a.out), 32'h8D);
        chk("order_msb", 32'(b.out), 32'hB1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // back-to-back
        send_word(8'hA5, 8'hFF);
        chk("b2b_first", 32'(a.out), 32'hA5);
        send_word(8'h3C, 8'hFF);
        chk("b2b_second", 32'(a.out), 32'h3C);
        cyc(0, 0, 0, 1, 0);

        // backpressure and overrun
        send_word(8'h11, 8'h00);
        send_word(8'h22, 8'h00);
        chk("bp_held", 32'(a.out), 32'h11);
        chk("bp_ovr", 32'(a.overrun), 32'h1);
        cyc(0, 0, 0, 1, 0);
        chk("bp_drop", 32'(a.out_valid), 32'h0);
        cyc(0, 0, 0, 1, 0);

        // resync
        for (int i = 0; i < 5; i++)
            cyc(1, 1'($urandom), 0, 1, 0);
        chk("rs_cnt5", 32'(a.bit_count), 32'd5);
        cyc(1, 1, 1, 1, 0);
        chk("rs_cnt1", 32'(a.bit_count), 32'd1);
        for (int i = 0; i < 7; i++)
            cyc(1, 1, 0, 1, 0);
        chk("rs_word", 32'(a.out), 32'hFF);
        cyc(0, 0, 0, 1, 0);

        // simultaneous consume and complete
        cyc(0, 0, 0, 0, 1);
        send_word(8'h11, 8'h00);
        send_word(8'h22, 8'h80);
        chk("sim_out", 32'(a.out), 32'h22);
        chk("sim_valid", 32'(a.out_valid), 32'h1);
        chk("sim_ovr", 32'(a.overrun), 32'h0);

        // mid-word reset
        for (int i = 0; i < 4; i++)
            cyc(1, 1'($urandom), 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        chk("mr_valid", 32'(a.out_valid), 32'h0);
        chk("mr_out", 32'(a.out), 32'h0);
        send_word(8'h5A, 8'hFF);
        chk("mr_word", 32'(a.out), 32'h5A);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom),
                $urandom_range(0, 15) == 0, 1'($urandom),
                $urandom_range(0, 99) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end
endmodule
